// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths and time types for the PWM generator slice.
// Build option: PWM_UPDATE_SYNC_EN (see pwm_gen.sv).
package pwm_pkg;

    // Default bit width of TIME_CNT, CYCLE, DUTY and PHASE
    localparam int WIDTH_DEF = 13;

    // Time value inside one PWM period
    typedef logic [WIDTH_DEF-1:0] time_t;

    // One extra bit so sums like PHASE + DUTY/2 cannot overflow
    typedef logic [WIDTH_DEF:0] time_ext_t;

endpackage

// File: rtl/pwm_gen_if.sv
// pwm_gen_if: time/duty/phase bundle shared between the time-counter side
// (master) and one transducer PWM generator (slave).
interface pwm_gen_if
    import pwm_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) ();

    logic [WIDTH-1:0] TIME_CNT;
    logic [WIDTH-1:0] CYCLE;
    logic [WIDTH-1:0] DUTY;
    logic [WIDTH-1:0] PHASE;
    logic             PWM_OUT;

    modport master (
        output TIME_CNT,
        output CYCLE,
        output DUTY,
        output PHASE,
        input  PWM_OUT
    );

    modport slave (
        input  TIME_CNT,
        input  CYCLE,
        input  DUTY,
        input  PHASE,
        output PWM_OUT
    );

endinterface

// File: rtl/pwm_edge_calc.sv
// pwm_edge_calc: combinational rise/fall edge positions for a pulse of
// length duty centred on phase, wrapped modulo cycle, plus the all-low and
// all-high mode flags. The caller registers the results.
module pwm_edge_calc
    import pwm_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] duty_i,
    input  logic [WIDTH-1:0] phase_i,
    input  logic [WIDTH-1:0] cycle_i,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic             zero_o,
    output logic             full_o
);

    logic [WIDTH:0] dutyExt;
    logic [WIDTH:0] phaseExt;
    logic [WIDTH:0] cycleExt;
    logic [WIDTH:0] loHalf;
    logic [WIDTH:0] hiHalf;
    logic [WIDTH:0] phasePlusHi;
    logic [WIDTH:0] riseExt;
    logic [WIDTH:0] fallExt;

    // Split duty into two halves around phase (odd duty puts the extra clock
    // after phase) and fold both edges back into 0..cycle-1
    always_comb begin
        dutyExt     = {1'b0, duty_i};
        phaseExt    = {1'b0, phase_i};
        cycleExt    = {1'b0, cycle_i};
        loHalf      = dutyExt >> 1;
        hiHalf      = (dutyExt + 1'b1) >> 1;
        phasePlusHi = phaseExt + hiHalf;

        if (phaseExt >= loHalf) begin
            riseExt = phaseExt - loHalf;
        end else begin
            riseExt = phaseExt - loHalf + cycleExt;
        end

        if (phasePlusHi >= cycleExt) begin
            fallExt = phasePlusHi - cycleExt;
        end else begin
            fallExt = phasePlusHi;
        end

        rise_o = WIDTH'(riseExt);
        fall_o = WIDTH'(fallExt);
        zero_o = (duty_i == '0);
        full_o = (duty_i >= cycle_i);
    end

endmodule

// File: rtl/pwm_gen.sv
// pwm_gen: per-transducer PWM drive bit derived from the shared time counter.
// Three register stages: S1 samples time and shadows DUTY/PHASE, S2 registers
// the edge positions, S3 registers the compare result onto PWM_OUT.
// Build option PWM_UPDATE_SYNC_EN: when defined, DUTY/PHASE shadows load only
// when the time counter wraps (tear-free periods); when undefined they load
// every clock (transparent update for debug) and no wrap comparator exists.
module pwm_gen
    import pwm_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic      CLK,
    input  logic      RST_N,
    pwm_gen_if.slave  bus
);

    logic [WIDTH-1:0] t1_q;
    logic [WIDTH-1:0] t2_q;
    logic [WIDTH-1:0] dutyShadow_q;
    logic [WIDTH-1:0] dutyShadow_d;
    logic [WIDTH-1:0] phaseShadow_q;
    logic [WIDTH-1:0] phaseShadow_d;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] fall_d;
    logic             zero_q;
    logic             zero_d;
    logic             full_q;
    logic             full_d;
    logic             pwmOut_q;
    logic             pwmOut_d;

`ifdef PWM_UPDATE_SYNC_EN
    logic wrap;

    // A backwards step of the time counter marks a new period; this also
    // catches the jump caused by shrinking CYCLE mid-period
    assign wrap = (bus.TIME_CNT < t1_q);
`endif

    // Choose the next shadow values: hold until a wrap, or follow the inputs
    always_comb begin
        dutyShadow_d  = dutyShadow_q;
        phaseShadow_d = phaseShadow_q;
`ifdef PWM_UPDATE_SYNC_EN
        if (wrap) begin
            dutyShadow_d  = bus.DUTY;
            phaseShadow_d = bus.PHASE;
        end
`else
        dutyShadow_d  = bus.DUTY;
        phaseShadow_d = bus.PHASE;
`endif
    end

    // S1: sample the time counter and update the duty/phase shadows together,
    // so the first sample of a period travels with that period's settings
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            t1_q          <= '0;
            dutyShadow_q  <= '0;
            phaseShadow_q <= '0;
        end else begin
            t1_q          <= bus.TIME_CNT;
            dutyShadow_q  <= dutyShadow_d;
            phaseShadow_q <= phaseShadow_d;
        end
    end

    pwm_edge_calc #(
        .WIDTH (WIDTH)
    ) uEdgeCalc (
        .duty_i  (dutyShadow_q),
        .phase_i (phaseShadow_q),
        .cycle_i (bus.CYCLE),
        .rise_o  (rise_d),
        .fall_o  (fall_d),
        .zero_o  (zero_d),
        .full_o  (full_d)
    );

    // S2: delay the time sample alongside the edge positions computed from it
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            t2_q   <= '0;
            rise_q <= '0;
            fall_q <= '0;
            zero_q <= 1'b0;
            full_q <= 1'b0;
        end else begin
            t2_q   <= t1_q;
            rise_q <= rise_d;
            fall_q <= fall_d;
            zero_q <= zero_d;
            full_q <= full_d;
        end
    end

    // Window compare; equal edges only occur in the cleared post-reset state
    // (a legal partial duty never gives rise == fall), so they mean "no pulse"
    always_comb begin
        pwmOut_d = 1'b0;
        if (zero_q) begin
            pwmOut_d = 1'b0;
        end else if (full_q) begin
            pwmOut_d = 1'b1;
        end else if (rise_q <= fall_q) begin
            pwmOut_d = (t2_q >= rise_q) && (t2_q < fall_q);
        end else begin
            pwmOut_d = (t2_q >= rise_q) || (t2_q < fall_q);
        end
    end

    // S3: register the drive bit so the transducer sees a glitch-free output
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pwmOut_q <= 1'b0;
        end else begin
            pwmOut_q <= pwmOut_d;
        end
    end

    assign bus.PWM_OUT = pwmOut_q;

endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: directed bench for pwm_gen. A free-running time counter is
// driven every clock; each driven sample gets a hand-derived expected bit
// that is compared against PWM_OUT three clocks after it was applied.
module tb_pwm_gen;
    import pwm_pkg::*;

    typedef struct {
        logic expBit;
        bit   care;
        int   tVal;
    } sample_t;

    logic clk = 1'b0;
    logic rstN;

    int compared   = 0;
    int mismatched = 0;

    int tCnt     = 0;
    int cycleCfg = 512;
    int dutyCfg  = 256;
    int phaseCfg = 256;
    int shDuty   = 0;
    int shPhase  = 0;
    int prevT    = 0;

    sample_t pipe[$];

    pwm_gen_if #(.WIDTH(WIDTH_DEF)) bus ();

    pwm_gen #(
        .WIDTH (WIDTH_DEF)
    ) dut (
        .CLK   (clk),
        .RST_N (rstN),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Expected drive bit: high when t lies within duty clocks starting
    // duty/2 before phase, measured around the circular period
    function automatic logic expectedBit(int t, int duty, int phase, int cyc);
        int off;
        if (duty == 0) return 1'b0;
        if (duty >= cyc) return 1'b1;
        off = (t + cyc - phase + duty / 2) % cyc;
        return (off < duty);
    endfunction

    // Drive one time sample with the current settings, advance one clock and
    // hand back the sample whose result is now on PWM_OUT
    task automatic applyStimulus(output bit got, output sample_t s, output logic obs);
        sample_t e;
        bus.TIME_CNT = time_t'(tCnt);
        bus.CYCLE    = time_t'(cycleCfg);
        bus.DUTY     = time_t'(dutyCfg);
        bus.PHASE    = time_t'(phaseCfg);
        e.tVal = tCnt;
        e.care = 1'b1;
        if (!rstN) begin
            shDuty  = 0;
            shPhase = 0;
            prevT   = 0;
            foreach (pipe[k]) pipe[k].expBit = 1'b0;
            e.expBit = 1'b0;
        end else begin
`ifdef PWM_UPDATE_SYNC_EN
            if (tCnt < prevT) begin
                shDuty  = dutyCfg;
                shPhase = phaseCfg;
            end
`else
            shDuty  = dutyCfg;
            shPhase = phaseCfg;
`endif
            prevT    = tCnt;
            e.expBit = expectedBit(tCnt, shDuty, shPhase, cycleCfg);
        end
        pipe.push_back(e);
        @(posedge clk);
        #1;
        tCnt = (tCnt + 1) % cycleCfg;
        got = 1'b0;
        s   = e;
        if (pipe.size() == 3) begin
            s   = pipe.pop_front();
            got = 1'b1;
        end
        obs = bus.PWM_OUT;
    endtask

    task automatic test_reset();
        bit got; sample_t s; logic obs;
        rstN = 1'b0;
        for (int n = 0; n < 6; n++) begin
            applyStimulus(got, s, obs);
            compared++;
            if (obs !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL reset n=%0d: PWM_OUT=%b, expected 0", n, obs);
            end
        end
        rstN = 1'b1;
    endtask

    task automatic test_centered();
        bit got; sample_t s; logic obs; int highs = 0;
        cycleCfg = 512; dutyCfg = 256; phaseCfg = 256;
        for (int n = 0; n < 1100; n++) begin
            applyStimulus(got, s, obs);
            if (got && s.care) begin
                compared++;
                if (obs !== s.expBit) begin
                    mismatched++;
                    $display("[TB] FAIL centered t=%0d: PWM_OUT=%b, expected %b", s.tVal, obs, s.expBit);
                end
            end
            if (n >= 588 && obs === 1'b1) highs++;
        end
        compared++;
        if (highs != 256) begin
            mismatched++;
            $display("[TB] FAIL centered_width: %0d high clocks, expected 256", highs);
        end
    endtask

    task automatic test_straddle();
        bit got; sample_t s; logic obs; int highs = 0;
        dutyCfg = 256; phaseCfg = 0;
        for (int n = 0; n < 1100; n++) begin
            applyStimulus(got, s, obs);
            if (got && s.care) begin
                compared++;
                if (obs !== s.expBit) begin
                    mismatched++;
                    $display("[TB] FAIL straddle t=%0d: PWM_OUT=%b, expected %b", s.tVal, obs, s.expBit);
                end
            end
            if (n >= 588 && obs === 1'b1) highs++;
        end
        compared++;
        if (highs != 256) begin
            mismatched++;
            $display("[TB] FAIL straddle_width: %0d high clocks, expected 256", highs);
        end
    endtask

    task automatic test_zero_full();
        bit got; sample_t s; logic obs;
        int dutyList[3] = '{0, 512, 600};
        phaseCfg = 100;
        for (int k = 0; k < 3; k++) begin
            dutyCfg = dutyList[k];
            for (int n = 0; n < 600; n++) begin
                applyStimulus(got, s, obs);
                if (got && s.care) begin
                    compared++;
                    if (obs !== s.expBit) begin
                        mismatched++;
                        $display("[TB] FAIL zero_full duty=%0d t=%0d: PWM_OUT=%b, expected %b", dutyList[k], s.tVal, obs, s.expBit);
                    end
                end
            end
        end
    endtask

    task automatic test_single_clock();
        bit got; sample_t s; logic obs; int highs;
        int dutyList[2]  = '{1, 511};
        int phaseList[2] = '{10, 100};
        int wantHigh[2]  = '{1, 511};
        for (int k = 0; k < 2; k++) begin
            dutyCfg = dutyList[k]; phaseCfg = phaseList[k]; highs = 0;
            for (int n = 0; n < 1100; n++) begin
                applyStimulus(got, s, obs);
                if (got && s.care) begin
                    compared++;
                    if (obs !== s.expBit) begin
                        mismatched++;
                        $display("[TB] FAIL single duty=%0d t=%0d: PWM_OUT=%b, expected %b", dutyList[k], s.tVal, obs, s.expBit);
                    end
                end
                if (n >= 588 && obs === 1'b1) highs++;
            end
            compared++;
            if (highs != wantHigh[k]) begin
                mismatched++;
                $display("[TB] FAIL single_width duty=%0d: %0d high clocks, expected %0d", dutyList[k], highs, wantHigh[k]);
            end
        end
    endtask

    task automatic test_midperiod_update();
        bit got; sample_t s; logic obs;
        dutyCfg = 100; phaseCfg = 256;
        for (int n = 0; n < 1100; n++) begin
            if (n >= 512 && tCnt == 200) break;
            applyStimulus(got, s, obs);
            if (got && s.care) begin
                compared++;
                if (obs !== s.expBit) begin
                    mismatched++;
                    $display("[TB] FAIL update_pre t=%0d: PWM_OUT=%b, expected %b", s.tVal, obs, s.expBit);
                end
            end
        end
        dutyCfg = 300;
        for (int n = 0; n < 900; n++) begin
            applyStimulus(got, s, obs);
            if (got && s.care) begin
                compared++;
                if (obs !== s.expBit) begin
                    mismatched++;
                    $display("[TB] FAIL update_post t=%0d: PWM_OUT=%b, expected %b", s.tVal, obs, s.expBit);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit got; sample_t s; logic obs;
        dutyCfg = 256; phaseCfg = 256;
        for (int n = 0; n < 1100; n++) begin
            if (n >= 512 && tCnt == 300) break;
            applyStimulus(got, s, obs);
            if (got && s.care) begin
                compared++;
                if (obs !== s.expBit) begin
                    mismatched++;
                    $display("[TB] FAIL reset_mid_pre t=%0d: PWM_OUT=%b, expected %b", s.tVal, obs, s.expBit);
                end
            end
        end
        for (int n = 0; n < 1102; n++) begin
            rstN = (n < 2) ? 1'b0 : 1'b1;
            applyStimulus(got, s, obs);
            if (got && s.care) begin
                compared++;
                if (obs !== s.expBit) begin
                    mismatched++;
                    $display("[TB] FAIL reset_mid t=%0d: PWM_OUT=%b, expected %b", s.tVal, obs, s.expBit);
                end
            end
        end
    endtask

    task automatic test_cycle_change();
        bit got; sample_t s; logic obs;
        cycleCfg = 512; dutyCfg = 256; phaseCfg = 256;
        for (int n = 0; n < 1100; n++) begin
            if (n >= 512 && tCnt == 450) break;
            applyStimulus(got, s, obs);
            if (got && s.care) begin
                compared++;
                if (obs !== s.expBit) begin
                    mismatched++;
                    $display("[TB] FAIL cycle_pre t=%0d: PWM_OUT=%b, expected %b", s.tVal, obs, s.expBit);
                end
            end
        end
        // The sample just before the switch sees the new CYCLE in its edge stage
        pipe[pipe.size() - 1].care = 1'b0;
        cycleCfg = 400; dutyCfg = 200; phaseCfg = 300; tCnt = 50;
        for (int n = 0; n < 900; n++) begin
            applyStimulus(got, s, obs);
            if (got && s.care) begin
                compared++;
                if (obs !== s.expBit) begin
                    mismatched++;
                    $display("[TB] FAIL cycle_post t=%0d: PWM_OUT=%b, expected %b", s.tVal, obs, s.expBit);
                end
            end
        end
    endtask

    initial begin
        rstN = 1'b0;
        test_reset();
        test_centered();
        test_straddle();
        test_zero_full();
        test_single_clock();
        test_midperiod_update();
        test_reset_mid();
        test_cycle_change();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
